// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: instruction size,
// default reset vector and the fetch FSM state encoding.
package fetch_unit_pkg;

   localparam int unsigned INSTR_BYTES       = 4;
   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO holding {pc, instruction} pairs between memory and decode.
// A flush empties the queue and wins over a push in the same cycle.
module fetch_queue #(
   parameter int unsigned W     = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [W-1:0]             din_i,
   output logic [W-1:0]             dout_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;

   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign do_push = push_i && !flush_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   // Empty queue presents zeros so the head outputs are defined straight out of reset.
   assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding req/ack
// fetches and buffers {pc, instr} for decode, with redirect and back-pressure.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic              i_imem_ack,
   input  logic [DATA_W-1:0] i_imem_rdata,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_pc
);

   localparam int unsigned       CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

   fetch_state_e             state_q, state_d;
   logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic                     req_q, req_d;
   logic [ADDR_W-1:0]        target;
   logic                     xfer;
   logic                     q_push, q_pop, q_flush, q_empty, q_full;
   logic [CNT_W-1:0]         q_count, count_after;
   logic [ADDR_W+DATA_W-1:0] q_din, q_dout;

   assign target      = i_redirect_pc & ~(STEP - ADDR_W'(1));
   assign xfer        = req_q && i_imem_ack;
   assign q_pop       = !q_empty && i_ready;
   assign q_flush     = i_redirect;
   assign count_after = q_count + CNT_W'(1) - CNT_W'(q_pop);
   assign q_din       = {fetch_pc_q, i_imem_rdata};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_VEC;
         req_q      <= 1'b0;
         addr_q     <= RESET_VEC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!q_full && !i_redirect) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (i_redirect)                           state_d = xfer ? ST_IDLE : ST_DRAIN;
            else if (xfer && count_after == DEPTH_C)  state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (xfer) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request registers, fetch PC and queue push; a redirect always retargets fetch_pc.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      q_push     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (state_d == ST_REQ) begin
               req_d  = 1'b1;
               addr_d = fetch_pc_q;
            end
         end
         ST_REQ: begin
            if (xfer && !i_redirect) begin
               q_push     = 1'b1;
               fetch_pc_d = fetch_pc_q + STEP;
               if (state_d == ST_REQ) addr_d = fetch_pc_q + STEP;
               else                   req_d  = 1'b0;
            end else if (xfer) begin
               req_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (xfer) req_d = 1'b0;
         end
         default: ;
      endcase
      if (i_redirect) fetch_pc_d = target;
   end

   assign o_imem_req  = req_q;
   assign o_imem_addr = addr_q;
   assign o_valid     = !q_empty;
   assign {o_pc, o_instr} = q_dout;

   fetch_queue #(
      .W     (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .push_i  (q_push),
      .pop_i   (q_pop),
      .flush_i (q_flush),
      .din_i   (q_din),
      .dout_o  (q_dout),
      .count_o (q_count),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

endmodule
